// File: rtl/ddr_pkg.sv
// Shared types and constants for the dance-game note path.
// Used by the choreography stage and the note judge.
package ddr_pkg;
    localparam int LANES = 4;
    localparam int PERFECT_PTS = 3;
    localparam int GOOD_PTS = 1;
    localparam logic [15:0] SCORE_MAX = 16'hFFFF;
    localparam logic [7:0] COMBO_MAX = 8'hFF;

    typedef logic [LANES-1:0] lane_oh_t;

    typedef enum logic [1:0] {
        J_NONE,
        J_MISS,
        J_HIT,
        J_STRAY
    } judge_t;

    function automatic logic is_onehot(lane_oh_t v);
        return (v != '0) && ((v & (v - lane_oh_t'(1))) == '0);
    endfunction
endpackage

// File: rtl/lane_fifo.sv
// Per-lane FIFO of note spawn timestamps.
// Push and pop may happen in the same cycle; push into a full FIFO needs a pop.
module lane_fifo #(
    parameter int DEPTH = 4,
    parameter int TW = 10
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic [TW-1:0] din,
    output logic [TW-1:0] head,
    output logic          empty,
    output logic          full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0] CNT_ONE = 1;
    localparam logic [AW:0] CNT_FULL = DEPTH;

    logic [TW-1:0] mem_q [DEPTH];
    logic [TW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full = (cnt_q == CNT_FULL);
    assign head = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d = wr_q;
        rd_d = rd_q;
        cnt_d = cnt_q;
        do_pop = pop & ~empty;
        do_push = push & (~full | do_pop);
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d = wr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            mem_q <= '{default: '0};
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/note_judge.sv
// Tracks falling notes per lane and judges key presses against the target line.
// Emits hit/perfect/miss pulses and keeps saturating score and combo.
module note_judge
    import ddr_pkg::*;
#(
    parameter int TICK_DIV = 416666,
    parameter int TRAVEL = 240,
    parameter int WINDOW = 8,
    parameter int DEPTH = 4,
    parameter int TW = 10
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             step_pulse,
    input  logic [LANES-1:0] step_lane,
    input  logic [LANES-1:0] keys,
    output logic [LANES-1:0] hit_pulse,
    output logic [LANES-1:0] perfect_pulse,
    output logic [LANES-1:0] miss_pulse,
    output logic [15:0]      score,
    output logic [7:0]       combo,
    output logic [LANES-1:0] lane_pending,
    output logic             overflow
);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE = 1;
    localparam logic [TW-1:0] NOW_ONE = 1;
    localparam logic [TW-1:0] LATE = TW'(TRAVEL + WINDOW);
    localparam logic [TW-1:0] EARLY = TW'(TRAVEL - WINDOW);
    localparam logic [TW-1:0] P_LO = TW'(TRAVEL - WINDOW / 2);
    localparam logic [TW-1:0] P_HI = TW'(TRAVEL + WINDOW / 2);

    logic [DW-1:0] div_q, div_d;
    logic [TW-1:0] now_q, now_d;
    logic [LANES-1:0] key_q, key_d;
    logic [LANES-1:0] hit_q, hit_d, perfect_q, perfect_d, miss_q, miss_d;
    logic [15:0] score_q, score_d;
    logic [7:0] combo_q, combo_d;
    logic overflow_q, overflow_d;

    logic [LANES-1:0] key_edge, fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [TW-1:0] head [LANES];
    logic [TW-1:0] age [LANES];
    judge_t judge [LANES];
    logic spawn_ok, brk;
    logic [4:0] inc;
    logic [2:0] nhits;
    logic [16:0] score_sum;
    logic [8:0] combo_sum;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_fifo #(.DEPTH(DEPTH), .TW(TW)) u_fifo (
            .clock (clock),
            .resetn(resetn),
            .push  (fifo_push[g]),
            .pop   (fifo_pop[g]),
            .din   (now_q),
            .head  (head[g]),
            .empty (fifo_empty[g]),
            .full  (fifo_full[g])
        );
    end

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
        now_d = (div_q == DIV_LAST) ? now_q + NOW_ONE : now_q;
        key_d = keys;
        key_edge = keys & ~key_q;
        spawn_ok = step_pulse & is_onehot(step_lane);
        hit_d = '0;
        perfect_d = '0;
        miss_d = '0;
        fifo_pop = '0;
        fifo_push = '0;
        inc = '0;
        nhits = '0;
        brk = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            age[i] = now_q - head[i];
            judge[i] = J_NONE;
            // Expiry outranks a press so a late press is never credited.
            if (!fifo_empty[i] && age[i] > LATE) begin
                judge[i] = J_MISS;
            end else if (key_edge[i] && !fifo_empty[i]
                         && age[i] >= EARLY && age[i] <= LATE) begin
                judge[i] = J_HIT;
            end else if (key_edge[i]) begin
                judge[i] = J_STRAY;
            end
            case (judge[i])
                J_MISS: begin
                    miss_d[i] = 1'b1;
                    fifo_pop[i] = 1'b1;
                    brk = 1'b1;
                end
                J_HIT: begin
                    hit_d[i] = 1'b1;
                    fifo_pop[i] = 1'b1;
                    nhits = nhits + 3'd1;
                    if (age[i] >= P_LO && age[i] <= P_HI) begin
                        perfect_d[i] = 1'b1;
                        inc = inc + 5'(PERFECT_PTS);
                    end else begin
                        inc = inc + 5'(GOOD_PTS);
                    end
                end
                J_STRAY: brk = 1'b1;
                default: ;
            endcase
            fifo_push[i] = spawn_ok & step_lane[i]
                           & (~fifo_full[i] | fifo_pop[i]);
        end
        overflow_d = overflow_q
                     | (spawn_ok & |(step_lane & fifo_full & ~fifo_pop));
        score_sum = {1'b0, score_q} + {12'd0, inc};
        score_d = score_sum[16] ? SCORE_MAX : score_sum[15:0];
        combo_sum = {1'b0, combo_q} + {6'd0, nhits};
        combo_d = combo_sum[8] ? COMBO_MAX : combo_sum[7:0];
        if (brk) begin
            combo_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            div_q <= '0;
            now_q <= '0;
            key_q <= '1;
            hit_q <= '0;
            perfect_q <= '0;
            miss_q <= '0;
            score_q <= '0;
            combo_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            div_q <= div_d;
            now_q <= now_d;
            key_q <= key_d;
            hit_q <= hit_d;
            perfect_q <= perfect_d;
            miss_q <= miss_d;
            score_q <= score_d;
            combo_q <= combo_d;
            overflow_q <= overflow_d;
        end
    end

    assign hit_pulse = hit_q;
    assign perfect_pulse = perfect_q;
    assign miss_pulse = miss_q;
    assign score = score_q;
    assign combo = combo_q;
    assign lane_pending = ~fifo_empty;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_note_judge.sv
// Self-checking bench for note_judge with a short tick divider and travel.
// Expected outputs are queued when a press or expiry is scheduled.
module tb_note_judge;
    localparam int TDIV = 4;

    logic clock;
    logic resetn;
    logic step_pulse;
    logic [3:0] step_lane;
    logic [3:0] keys;
    logic [3:0] hit_pulse, perfect_pulse, miss_pulse, lane_pending;
    logic [15:0] score;
    logic [7:0] combo;
    logic overflow;

    note_judge #(
        .TICK_DIV(TDIV), .TRAVEL(20), .WINDOW(4), .DEPTH(4), .TW(10)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .step_pulse   (step_pulse),
        .step_lane    (step_lane),
        .keys         (keys),
        .hit_pulse    (hit_pulse),
        .perfect_pulse(perfect_pulse),
        .miss_pulse   (miss_pulse),
        .score        (score),
        .combo        (combo),
        .lane_pending (lane_pending),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string name;
        int due;
        logic [3:0] hit;
        logic [3:0] perf;
        logic [3:0] miss;
        logic [15:0] score;
        logic [7:0] combo;
    } exp_t;

    typedef struct {
        string name;
        logic [3:0] lane;
        int age;
        logic [3:0] hit;
        logic [3:0] perf;
        int pts;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int r = 0;
    int s = 0;
    int s0 = 0;
    logic [15:0] cur_score = 0;
    logic [7:0] cur_combo = 0;
    logic [15:0] exp_score = 0;
    logic [7:0] exp_combo = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h",
                     nm, cyc, act, req);
        end
    endtask

    // Advance one cycle; compare outputs against a due entry or idle values.
    task automatic step();
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            cur_score = e.score;
            cur_combo = e.combo;
            chk({e.name, ".hit"}, {28'd0, hit_pulse}, {28'd0, e.hit});
            chk({e.name, ".perfect"}, {28'd0, perfect_pulse}, {28'd0, e.perf});
            chk({e.name, ".miss"}, {28'd0, miss_pulse}, {28'd0, e.miss});
            chk({e.name, ".score"}, {16'd0, score}, {16'd0, e.score});
            chk({e.name, ".combo"}, {24'd0, combo}, {24'd0, e.combo});
        end else begin
            chk("idle.pulses", {20'd0, hit_pulse, perfect_pulse, miss_pulse}, 0);
            chk("idle.score_combo", {8'd0, score, combo},
                {8'd0, cur_score, cur_combo});
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic align();
        while (((cyc - r) % TDIV) != 0) step();
    endtask

    task automatic spawn(input logic [3:0] lane);
        step_pulse = 1'b1;
        step_lane = lane;
        step();
        step_pulse = 1'b0;
        step_lane = 4'b0000;
    endtask

    task automatic press(input string nm, input logic [3:0] mask,
                         input logic [3:0] hit, input logic [3:0] perf,
                         input int pts, input logic [7:0] new_combo);
        exp_t e;
        keys = keys | mask;
        exp_score = exp_score + 16'(pts);
        exp_combo = new_combo;
        e = '{nm, cyc + 1, hit, perf, 4'b0000, exp_score, exp_combo};
        sb.push_back(e);
        step();
        keys = keys & ~mask;
    endtask

    task automatic expect_miss(input string nm, input int due,
                               input logic [3:0] mask);
        exp_t e;
        exp_combo = 0;
        e = '{nm, due, 4'b0000, 4'b0000, mask, exp_score, 8'd0};
        sb.push_back(e);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, ".pulses"}, {20'd0, hit_pulse, perfect_pulse, miss_pulse}, 0);
        chk({nm, ".score"}, {16'd0, score}, 0);
        chk({nm, ".combo"}, {24'd0, combo}, 0);
        chk({nm, ".pending"}, {28'd0, lane_pending}, 0);
        chk({nm, ".overflow"}, {31'd0, overflow}, 0);
    endtask

    initial begin
        vecs[0] = '{"perfect_l0", 4'b0001, 20, 4'b0001, 4'b0001, 3};
        vecs[1] = '{"good_late_l2", 4'b0100, 24, 4'b0100, 4'b0000, 1};
        vecs[2] = '{"good_early_l1", 4'b0010, 16, 4'b0010, 4'b0000, 1};
        vecs[3] = '{"perfect_hi_l3", 4'b1000, 22, 4'b1000, 4'b1000, 3};
        vecs[4] = '{"perfect_lo_l1", 4'b0010, 18, 4'b0010, 4'b0010, 3};
        vecs[5] = '{"good_lo_l2", 4'b0100, 17, 4'b0100, 4'b0000, 1};

        resetn = 1'b1;
        keys = 4'b0000;
        step_pulse = 1'b0;
        step_lane = 4'b0000;
        repeat (3) step();
        resetn = 1'b0;
        r = cyc;
        chk_reset_state("reset");

        for (int i = 0; i < 6; i++) begin
            align();
            spawn(vecs[i].lane);
            s = cyc - 1;
            chk({vecs[i].name, ".pending_set"}, {28'd0, lane_pending},
                {28'd0, vecs[i].lane});
            run_to(s + TDIV * vecs[i].age);
            press(vecs[i].name, vecs[i].lane, vecs[i].hit, vecs[i].perf,
                  vecs[i].pts, exp_combo + 8'd1);
            chk({vecs[i].name, ".pending_clr"}, {28'd0, lane_pending}, 0);
        end

        // Lane 0 hit while lane 1 is pressed early: combo breaks, note stays.
        align();
        spawn(4'b0001);
        s0 = cyc - 1;
        run_to(s0 + TDIV * 10);
        spawn(4'b0010);
        run_to(s0 + TDIV * 20);
        press("hit_and_stray", 4'b0011, 4'b0001, 4'b0001, 3, 8'd0);
        chk("stray_age10.pending", {28'd0, lane_pending}, 32'h2);
        run_to(s0 + TDIV * 30);
        press("late_perfect_l1", 4'b0010, 4'b0010, 4'b0010, 3, 8'd1);
        step();
        press("stray_empty_l1", 4'b0010, 4'b0000, 4'b0000, 0, 8'd0);

        align();
        spawn(4'b0100);
        s = cyc - 1;
        run_to(s + TDIV * 20);
        press("perfect_l2", 4'b0100, 4'b0100, 4'b0100, 3, 8'd1);

        align();
        spawn(4'b1000);
        s = cyc - 1;
        expect_miss("expire_l3", s + TDIV * 25 + 1, 4'b1000);
        run_to(s + TDIV * 25 + 1);
        chk("expire_l3.pending", {28'd0, lane_pending}, 0);

        step_pulse = 1'b1;
        step_lane = 4'b0011;
        step();
        step_lane = 4'b0000;
        step();
        step_pulse = 1'b0;
        step();
        chk("bad_lane.pending", {28'd0, lane_pending}, 0);
        chk("bad_lane.overflow", {31'd0, overflow}, 0);

        align();
        s = cyc;
        repeat (4) spawn(4'b0001);
        chk("fill4.overflow", {31'd0, overflow}, 0);
        spawn(4'b0001);
        chk("fill5.overflow", {31'd0, overflow}, 1);
        chk("fill5.pending", {28'd0, lane_pending}, 32'h1);
        for (int k = 0; k < 4; k++)
            expect_miss("ovf_miss", s + TDIV * 25 + 1 + k, 4'b0001);
        run_to(s + TDIV * 25);
        spawn(4'b0001);
        run_to(s + TDIV * 25 + 10);
        chk("spawn_full_pop.pending", {28'd0, lane_pending}, 32'h1);
        chk("ovf_sticky", {31'd0, overflow}, 1);
        expect_miss("late_note_miss", s + TDIV * 50 + 1, 4'b0001);
        run_to(s + TDIV * 50 + 1);
        chk("late_note.pending", {28'd0, lane_pending}, 0);

        align();
        s = cyc;
        spawn(4'b0001);
        spawn(4'b1000);
        run_to(s + TDIV * 20);
        press("chord_l0_l3", 4'b1001, 4'b1001, 4'b1001, 6, exp_combo + 8'd2);

        align();
        spawn(4'b0010);
        spawn(4'b0100);
        run_to(cyc + 40);
        chk("pre_reset.pending", {28'd0, lane_pending}, 32'h6);
        keys = 4'b0001;
        resetn = 1'b1;
        cur_score = 0;
        cur_combo = 0;
        exp_score = 0;
        exp_combo = 0;
        step();
        step();
        resetn = 1'b0;
        r = cyc;
        chk_reset_state("mid_reset");
        run_to(cyc + 120);
        keys = 4'b0000;
        step();
        align();
        spawn(4'b0001);
        s = cyc - 1;
        run_to(s + TDIV * 20);
        press("post_reset_hit", 4'b0001, 4'b0001, 4'b0001, 3, 8'd1);
        repeat (3) step();

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: %0d expectations never checked",
                     sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
